// File: rtl/weight_stream_reader.sv
// weight_stream_reader: sweeps a wrap-around weight RAM window and streams each ternary code on a valid/ready port.
module weight_stream_reader #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_NEURON = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] aout,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [ADDR_WIDTH-1:0] w_index,
  output logic                  w_last,
  output logic                  busy,
  output logic                  done,
  output logic                  code_err
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  localparam logic [ADDR_WIDTH:0] MAX = (ADDR_WIDTH+1)'(NUM_NEURON);
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(NUM_NEURON - 1);
  localparam logic [DATA_WIDTH-1:0] RSVD = DATA_WIDTH'(2);
  logic [1:0] state;
  logic [ADDR_WIDTH:0] cnt, idx;
  logic err, load, fetch_last;
  assign load = state == RUN && !abort && (!w_valid || w_ready);
  assign fetch_last = idx == cnt - ONE;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  // The flag reflects a reserved code in the very cycle it is fetched.
  assign code_err = err | (load && dout == RSVD);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      aout <= '0;
      cnt <= '0;
      idx <= '0;
      err <= 1'b0;
      w_valid <= 1'b0;
      w_data <= '0;
      w_index <= '0;
      w_last <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      w_valid <= 1'b0;
      w_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        state <= count == '0 ? DONE : RUN;
        aout <= count == '0 ? aout : base_addr;
        cnt <= count > MAX ? MAX : count;
        idx <= '0;
        err <= 1'b0;
      end
      if (load) begin
        w_valid <= 1'b1;
        w_data <= dout;
        w_index <= idx[ADDR_WIDTH-1:0];
        w_last <= fetch_last;
        err <= err | (dout == RSVD);
        idx <= idx + ONE;
        state <= fetch_last ? DRAIN : RUN;
        aout <= fetch_last ? aout : (aout == TOP ? '0 : aout + 1'b1);
      end
      if (state == DRAIN && w_valid && w_ready) begin
        w_valid <= 1'b0;
        w_last <= 1'b0;
        state <= DONE;
      end
      if (state == DONE) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_weight_stream_reader.sv
// tb_weight_stream_reader: randomized scoreboard bench for the weight stream reader.
module tb_weight_stream_reader;
  logic clk = 0, reset = 1, start = 0, abort = 0, w_ready = 0;
  logic [8:0] base_addr = 0, aout, w_index;
  logic [9:0] count = 0;
  logic [1:0] dout, w_data;
  logic w_valid, w_last, busy, done, code_err;
  logic [1:0] ram [512];
  typedef struct packed {logic [1:0] d; logic [8:0] x; logic l;} beat_t;
  beat_t q[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign dout = ram[aout];

  weight_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .base_addr(base_addr),
    .count(count), .aout(aout), .dout(dout), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_index(w_index), .w_last(w_last), .busy(busy), .done(done),
    .code_err(code_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit err_upto(input int b, input int k);
    for (int i = 0; i < k; i++) if (ram[(b + i) % 512] == 2'b10) return 1;
    return 0;
  endfunction

  task automatic push_exp(input int b, input int n, output int eff);
    eff = n > 512 ? 512 : n;
    for (int i = 0; i < eff; i++) q.push_back(beat_t'{d: ram[(b + i) % 512], x: 9'(i), l: i == eff - 1});
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stream stability.
  logic pv = 0, pr = 0, pa = 0, prst = 1, pl = 0;
  logic [1:0] pd = 0;
  logic [8:0] px = 0;
  always @(negedge clk) begin
    beat_t e;
    if (!reset && w_valid && w_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected got_index=%0d want=none", w_index);
      end else begin
        e = q.pop_front();
        chk("beat_data", w_data, e.d);
        chk("beat_index", w_index, e.x);
        chk("beat_last", w_last, e.l);
      end
    end
    if (pv && !pr && !pa && !prst) begin
      chk("hold_valid", w_valid, 1);
      chk("hold_data", {w_data, w_index, w_last}, {pd, px, pl});
    end
    pv = w_valid; pr = w_ready; pa = abort; prst = reset;
    pd = w_data; px = w_index; pl = w_last;
  end

  // mode 0: ready high, 1: random ready, 2: ready low in cycles 3-6, 3: stray start in cycle 3
  task automatic sweep(input int b, input int n, input int mode);
    int eff, cyc;
    push_exp(b, n, eff);
    w_ready = 1; base_addr = 9'(b); count = 10'(n); start = 1;
    @(posedge clk); #1;
    start = 0; cyc = 1;
    chk("busy_c1", busy, eff != 0);
    if (eff == 0) chk("no_valid_c1", w_valid, 0);
    while (1) begin
      w_ready = mode == 1 ? $urandom_range(0, 3) != 0 : mode == 2 ? !(cyc >= 3 && cyc <= 6) : 1'b1;
      start = mode == 3 && cyc == 3;
      base_addr = 9'($urandom);
      count = 10'($urandom_range(1, 20));
      if ((mode == 0 || mode == 3) && cyc <= eff) begin
        chk("aout_seq", aout, (b + cyc - 1) % 512);
        chk("code_err_run", code_err, err_upto(b, cyc));
      end
      if (mode == 2 && cyc >= 3 && cyc <= 6) chk("aout_stall", aout, (b + 2) % 512);
      if (done || cyc >= 3000) break;
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    chk("done_seen", done, 1);
    if (mode == 0 || mode == 3) chk("done_cycle", cyc, eff == 0 ? 1 : eff + 2);
    if (mode == 2) chk("done_cycle", cyc, eff + 6);
    chk("queue_empty", q.size(), 0);
    chk("code_err_end", code_err, err_upto(b, eff));
    @(posedge clk); #1;
    chk("done_pulse_len", done, 0);
    chk("idle_busy", busy, 0);
    q.delete();
  endtask

  initial begin
    int eff, b;
    for (int i = 0; i < 512; i++) ram[i] = 2'(i % 4);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_valid", w_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_err", code_err, 0); chk("rst_aout", aout, 0);
    sweep(0, 4, 0);
    sweep(510, 4, 0);
    for (int i = 0; i < 512; i++) ram[i] = 2'($urandom);
    sweep(20, 5, 2);
    sweep(100, 0, 0);
    sweep($urandom_range(0, 511), 600, 0);
    sweep(30, 10, 3);
    // abort while beat 2 of 8 is presented
    b = $urandom_range(0, 511);
    push_exp(b, 8, eff);
    w_ready = 1; base_addr = 9'(b); count = 10'd8; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 chk("abort_beat2", w_index, 2);
    abort = 1; w_ready = 0;
    @(posedge clk); #1;
    abort = 0; w_ready = 1;
    q.delete();
    chk("abort_valid", w_valid, 0); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    chk("abort_err_kept", code_err, err_upto(b, 3));
    repeat (3) begin
      @(posedge clk); #1 chk("abort_no_done", done, 0);
    end
    sweep(7, 2, 0);
    repeat (6) sweep($urandom_range(0, 511), $urandom_range(1, 40), 1);
    // reset mid-sweep
    push_exp(5, 20, eff);
    w_ready = 1; base_addr = 9'd5; count = 10'd20; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 w_ready = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    q.delete();
    chk("mrst_valid", w_valid, 0); chk("mrst_busy", busy, 0); chk("mrst_done", done, 0);
    chk("mrst_err", code_err, 0); chk("mrst_aout", aout, 0);
    sweep(300, 3, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/weight_stream_reader.md
# weight_stream_reader

Sequential read-side engine for the neuron weight RAM. On `start` it sweeps a contiguous, wrap-around address window of the RAM's asynchronous read port (`aout`/`dout`), one address per cycle. Each ternary weight it fetches is delivered as a beat on a valid/ready stream to the neuron update datapath. It also flags reserved weight encodings.

## Interface
- `DATA_WIDTH`, 2: weight width (ternary code).
- `ADDR_WIDTH`, 9: RAM address width.
- `NUM_NEURON`, 512: RAM depth; must be ≤ 2**ADDR_WIDTH.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `abort`  in  1  cancel sweep; takes priority over everything except `reset`.
- `base_addr`  in  ADDR_WIDTH  first RAM address; sampled with `start`.
- `count`  in  ADDR_WIDTH+1  number of weights; sampled with `start`.
- `aout`  out  ADDR_WIDTH  RAM read address.
- `dout`  in  DATA_WIDTH  RAM read data; combinational from `aout` in the same cycle.
- `w_valid`  out  1  output beat valid.
- `w_ready`  in  1  consumer accepts beat.
- `w_data`  out  DATA_WIDTH  raw weight code.
- `w_index`  out  ADDR_WIDTH  beat offset within the sweep (0..count-1).
- `w_last`  out  1  marks the final beat of the sweep.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle completion pulse.
- `code_err`  out  1  sticky flag: a reserved code was fetched.

## Operation
- **Reset.** All outputs are 0, state is IDLE, and the output register is empty.
- **States.** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`. Latch `base_addr`. Latch `count`, clamped to NUM_NEURON if larger. Clear `code_err`.
  - IDLE → DONE on `start` with `count`=0. No beats are emitted.
  - RUN → DRAIN once the last address has been fetched into the output register.
  - DRAIN → DONE on the handshake of the `w_last` beat.
  - DONE → IDLE unconditionally after 1 cycle.
- **Fetch.** `aout` = (base + fetch_idx) mod NUM_NEURON, so the address after NUM_NEURON-1 is 0. In RUN, when the output register is empty or being drained (`!w_valid || w_ready`), it loads {`dout`, fetch_idx, fetch_idx==count-1}, and fetch_idx increments. Otherwise `aout` and fetch_idx hold.
- **Stream rules.**
  - While `w_valid && !w_ready`, `w_data`, `w_index` and `w_last` are stable.
  - `w_valid` never drops without a handshake, except on `abort` or `reset`.
- **Weight codes.** 2'b00 = 0, 2'b01 = +1, 2'b11 = −1, 2'b10 = reserved. Reserved data is forwarded unchanged and sets `code_err`. `code_err` holds until the next accepted `start` or `reset`.
- **busy.** High in RUN and DRAIN; low in IDLE and DONE.
- **Ignored inputs.**
  - `start` is ignored outside IDLE.
  - `base_addr` and `count` are ignored outside the `start` cycle.
- **abort.** In any state, the next cycle is IDLE with `w_valid`=0, `busy`=0 and no `done` pulse. `code_err` is retained.
- **Write coherency.** RAM writes during a sweep are not tracked. Each beat carries the RAM content in its fetch cycle.
- **Idle address.** In IDLE/DONE, `aout` holds its last value (0 after reset).

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: RUN, `busy`=1, `aout`=base_addr.
- Cycle 2: first `w_valid`.
- With `w_ready` held high, throughput is 1 beat/cycle. Beat k is valid in cycle 2+k.
- `done` is high for exactly 1 cycle, in the cycle after the `w_last` handshake.
- `count`=0: `done`=1 in cycle 1 and `w_valid` is never asserted.
- Back-to-back sweeps: the earliest next `start` is in the cycle after `done`, once the block is back in IDLE. Per sweep the overhead is 3 cycles beyond N beats.
- `w_ready` is not required combinationally before `w_valid`. The block takes no combinational path from `w_ready` to `w_valid`.

## Test plan
- **Reset.** Assert `reset` for 2 cycles mid-sweep → next cycle `w_valid`, `busy`, `done`, `code_err`, `aout` are all 0, and the state is IDLE.
- **Basic sweep.** RAM[i] = i mod 4; `start` with base=0, count=4, `w_ready`=1.
  - `aout` = 0, 1, 2, 3 in cycles 1–4.
  - `w_data` = 00, 01, 10, 11 and `w_index` = 0..3 in cycles 2–5.
  - `w_last` only in cycle 5; `done` in cycle 6.
  - `code_err`=1 from cycle 3 onward.
- **Wrap-around.** NUM_NEURON=512, base=510, count=4.
  - `aout` sequence = 510, 511, 0, 1.
  - `w_index` = 0..3, with `w_last` on `w_index`=3.
- **Backpressure.** count=5, `w_ready` low during cycles 3–6.
  - `w_data`/`w_index` frozen on beat 1 and `aout` stalled.
  - All 5 beats are delivered in order with none duplicated or dropped.
  - `done` comes 1 cycle after the final handshake.
- **Count edge cases.**
  - count=0 → `done` pulse in cycle 1, no `w_valid`.
  - count=600 → clamped: exactly 512 beats, `w_last` on index 511.
- **Control.**
  - `start` pulsed while `busy` → ignored; the sweep completes unchanged.
  - `abort` on beat 2 of 8 → `w_valid`=0 next cycle and no `done`.
  - A subsequent `start` (base=7, count=2) → beats come from addresses 7 and 8.
